// File: rtl/adxl362_spi_responder.sv
// adxl362_spi_responder
//   SPI mode-0 responder that emulates the ADXL362 register interface. It runs
//   in the system clock domain and oversamples the SPI pins (clk >= 8x SCLK).
//   Serves X/Y/Z samples captured from ports and holds FILTER_CTL/POWER_CTL.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high
//   sclk/ss/mosi   SPI pins from the master (ss active-low, MSB first)
//   miso           SPI data to the master
//   accel_x/y/z    12-bit two's complement samples
//   sample_strobe  one-clk pulse, new sample on accel_x/y/z
//   power_ctl      POWER_CTL register (0x2D)
//   filter_ctl     FILTER_CTL register (0x2C)
//   bad_cmd        one-clk pulse on an unsupported command byte
module adxl362_spi_responder #(
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] PARTID      = 8'hF2,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sclk,
    input  logic               ss,
    input  logic               mosi,
    output logic               miso,
    input  logic signed [11:0] accel_x,
    input  logic signed [11:0] accel_y,
    input  logic signed [11:0] accel_z,
    input  logic               sample_strobe,
    output logic [7:0]         power_ctl,
    output logic [7:0]         filter_ctl,
    output logic               bad_cmd
);
    localparam int         SYNC_N    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_WRITE = 8'h0A;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WR, RD, IGNORE} state_t;
    state_t state, state_nxt;

    logic [SYNC_N-1:0] sclk_sync, ss_sync, mosi_sync;
    logic              sclk_prev;
    logic              sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, byte_done;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx_shift;
    logic [6:0]        tx_shift;
    logic [7:0]        rx_byte, addr, rd_data;
    logic              rd_mode, armed, data_ready, pending, soft_pend, bad_cmd_nxt;
    logic signed [11:0] shadow_x, shadow_y, shadow_z;
    logic signed [11:0] pend_x, pend_y, pend_z;

    // Synchronizers are left out of reset so ss_s always reflects the real pin.
    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[SYNC_N-2:0], sclk};
        ss_sync   <= {ss_sync[SYNC_N-2:0], ss};
        mosi_sync <= {mosi_sync[SYNC_N-2:0], mosi};
        sclk_prev <= sclk_sync[SYNC_N-1];
    end

    assign sclk_s    = sclk_sync[SYNC_N-1];
    assign ss_s      = ss_sync[SYNC_N-1];
    assign mosi_s    = mosi_sync[SYNC_N-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign rx_byte   = {rx_shift, mosi_s};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            8'h00:   rd_data = DEVID_AD;
            8'h01:   rd_data = 8'h1D;
            8'h02:   rd_data = PARTID;
            8'h03:   rd_data = 8'h01;
            8'h08:   rd_data = shadow_x[11:4];
            8'h09:   rd_data = shadow_y[11:4];
            8'h0A:   rd_data = shadow_z[11:4];
            8'h0B:   rd_data = {7'b0, data_ready};
            8'h0E:   rd_data = shadow_x[7:0];
            8'h0F:   rd_data = {{4{shadow_x[11]}}, shadow_x[11:8]};
            8'h10:   rd_data = shadow_y[7:0];
            8'h11:   rd_data = {{4{shadow_y[11]}}, shadow_y[11:8]};
            8'h12:   rd_data = shadow_z[7:0];
            8'h13:   rd_data = {{4{shadow_z[11]}}, shadow_z[11:8]};
            8'h2C:   rd_data = filter_ctl;
            8'h2D:   rd_data = power_ctl;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bad_cmd_nxt = 1'b0;
        case (state)
            IDLE: if (armed && !ss_s) state_nxt = CMD;
            CMD: begin
                if (byte_done) begin
                    if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
                        state_nxt = ADDR;
                    end else begin
                        state_nxt   = IGNORE;
                        bad_cmd_nxt = 1'b1;
                    end
                end
            end
            ADDR:    if (byte_done) state_nxt = rd_mode ? RD : WR;
            default: state_nxt = state;
        endcase
        // Deselect aborts whatever frame is in progress.
        if (state != IDLE && ss_s) begin
            state_nxt   = IDLE;
            bad_cmd_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            miso       <= 1'b0;
            power_ctl  <= 8'h00;
            filter_ctl <= 8'h13;
            bad_cmd    <= 1'b0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            addr       <= '0;
            rd_mode    <= 1'b0;
            armed      <= 1'b0;
            data_ready <= 1'b0;
            pending    <= 1'b0;
            soft_pend  <= 1'b0;
            shadow_x   <= '0;
            shadow_y   <= '0;
            shadow_z   <= '0;
            pend_x     <= '0;
            pend_y     <= '0;
            pend_z     <= '0;
        end else begin
            bad_cmd <= bad_cmd_nxt;
            if (ss_s) armed <= 1'b1;

            if (state == IDLE || ss_s) begin
                bit_cnt <= '0;
                miso    <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                case (state)
                    CMD:  if (byte_done) rd_mode <= (rx_byte == CMD_READ);
                    ADDR: if (byte_done) addr <= rx_byte;
                    WR: begin
                        if (byte_done) begin
                            case (addr)
                                8'h2C:   filter_ctl <= rx_byte;
                                8'h2D:   power_ctl  <= rx_byte;
                                8'h1F:   if (rx_byte == 8'h52) soft_pend <= 1'b1;
                                default: ;
                            endcase
                            addr <= addr + 8'd1;
                        end
                    end
                    RD: begin
                        if (sclk_fall) begin
                            if (bit_cnt == 3'd0) begin
                                // Byte boundary: present the MSB before the next rising edge.
                                miso     <= rd_data[7];
                                tx_shift <= rd_data[6:0];
                                addr     <= addr + 8'd1;
                                if ((addr >= 8'h08 && addr <= 8'h0A) ||
                                    (addr >= 8'h0E && addr <= 8'h13))
                                    data_ready <= 1'b0;
                            end else begin
                                miso     <= tx_shift[6];
                                tx_shift <= {tx_shift[5:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
            end

            // Captures land after the clear above so a same-cycle set wins.
            if (sample_strobe && power_ctl[1:0] == 2'b10) begin
                if (ss_s) begin
                    shadow_x   <= accel_x;
                    shadow_y   <= accel_y;
                    shadow_z   <= accel_z;
                    data_ready <= 1'b1;
                    pending    <= 1'b0;
                end else begin
                    // Keep the frame coherent; commit once ss goes high.
                    pend_x  <= accel_x;
                    pend_y  <= accel_y;
                    pend_z  <= accel_z;
                    pending <= 1'b1;
                end
            end else if (pending && ss_s) begin
                shadow_x   <= pend_x;
                shadow_y   <= pend_y;
                shadow_z   <= pend_z;
                data_ready <= 1'b1;
                pending    <= 1'b0;
            end

            if (soft_pend && ss_s) begin
                power_ctl  <= 8'h00;
                filter_ctl <= 8'h13;
                shadow_x   <= '0;
                shadow_y   <= '0;
                shadow_z   <= '0;
                data_ready <= 1'b0;
                pending    <= 1'b0;
                soft_pend  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Bench for adxl362_spi_responder: directed scenarios plus randomized
// register traffic checked against a register-map reference model.
module tb_adxl362_spi_responder;
    localparam int HALF = 40;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sclk = 1'b0;
    logic               ss = 1'b1;
    logic               mosi = 1'b0;
    logic               miso;
    logic signed [11:0] accel_x = '0, accel_y = '0, accel_z = '0;
    logic               sample_strobe = 1'b0;
    logic [7:0]         power_ctl, filter_ctl;
    logic               bad_cmd;

    adxl362_spi_responder dut (
        .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
        .sample_strobe(sample_strobe), .power_ctl(power_ctl),
        .filter_ctl(filter_ctl), .bad_cmd(bad_cmd)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int bad_cnt = 0;

    always @(negedge clk) if (bad_cmd) bad_cnt++;

    // Reference model state
    int         m_x = 0, m_y = 0, m_z = 0;
    int         p_x = 0, p_y = 0, p_z = 0;
    bit         m_dr = 0, m_pend = 0, m_soft = 0;
    logic [7:0] m_power = 8'h00, m_filter = 8'h13;

    logic [7:0] tx_buf [0:15];
    logic [7:0] rx_buf [0:15];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input int a);
        case (a & 255)
            8'h00: return 8'hAD;
            8'h01: return 8'h1D;
            8'h02: return 8'hF2;
            8'h03: return 8'h01;
            8'h08: return 8'((m_x >>> 4) & 255);
            8'h09: return 8'((m_y >>> 4) & 255);
            8'h0A: return 8'((m_z >>> 4) & 255);
            8'h0B: return {7'b0, m_dr};
            8'h0E: return 8'(m_x & 255);
            8'h0F: return 8'((m_x >>> 8) & 255);
            8'h10: return 8'(m_y & 255);
            8'h11: return 8'((m_y >>> 8) & 255);
            8'h12: return 8'(m_z & 255);
            8'h13: return 8'((m_z >>> 8) & 255);
            8'h2C: return m_filter;
            8'h2D: return m_power;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void m_load(input int a);
        int b = a & 255;
        if ((b >= 8 && b <= 10) || (b >= 14 && b <= 19)) m_dr = 0;
    endfunction

    function automatic void m_reset();
        m_x = 0; m_y = 0; m_z = 0; m_dr = 0; m_pend = 0; m_soft = 0;
        m_power = 8'h00; m_filter = 8'h13;
    endfunction

    function automatic void m_frame_end();
        if (m_pend) begin
            m_x = p_x; m_y = p_y; m_z = p_z; m_dr = 1; m_pend = 0;
        end
        if (m_soft) m_reset();
    endfunction

    task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            #(HALF);
            r[i] = miso;
            sclk = 1'b1;
            #(HALF);
            sclk = 1'b0;
        end
    endtask

    // n bytes; the final byte is cut short to last_bits bits.
    task automatic spi_frame(input int n, input int last_bits);
        logic [7:0] r;
        @(posedge clk); #2;
        ss = 1'b0;
        #(HALF);
        for (int k = 0; k < n; k++) begin
            spi_byte(tx_buf[k], (k == n - 1) ? last_bits : 8, r);
            rx_buf[k] = r;
        end
        #(HALF);
        ss = 1'b1;
        mosi = 1'b0;
        repeat (8) @(posedge clk);
        #2;
    endtask

    task automatic do_read(input logic [7:0] start, input int n);
        logic [7:0] a;
        tx_buf[0] = 8'h0B;
        tx_buf[1] = start;
        for (int k = 0; k < n; k++) tx_buf[2 + k] = 8'h00;
        spi_frame(n + 2, 8);
        for (int k = 0; k < n; k++) begin
            a = start + 8'(k);
            chk($sformatf("rd_%02h", a), rx_buf[2 + k], m_read(a));
            m_load(a);
        end
        m_load(start + n);  // the trailing falling edge loads one more address
        m_frame_end();
    endtask

    task automatic do_write(input logic [7:0] start, input int n,
                            input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] d, a;
        tx_buf[0] = 8'h0A;
        tx_buf[1] = start;
        tx_buf[2] = d0;
        tx_buf[3] = d1;
        spi_frame(n + 2, 8);
        for (int k = 0; k < n; k++) begin
            a = start + 8'(k);
            d = (k == 0) ? d0 : d1;
            if (a == 8'h2C) m_filter = d;
            if (a == 8'h2D) m_power = d;
            if (a == 8'h1F && d == 8'h52) m_soft = 1;
        end
        m_frame_end();
        chk("power_ctl", power_ctl, m_power);
        chk("filter_ctl", filter_ctl, m_filter);
    endtask

    task automatic strobe_pins(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
        @(posedge clk); #2;
        accel_x = x; accel_y = y; accel_z = z;
        sample_strobe = 1'b1;
        @(posedge clk); #2;
        sample_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic do_strobe(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
        strobe_pins(x, y, z);
        if (m_power[1:0] == 2'b10) begin
            m_x = int'($signed(x)); m_y = int'($signed(y)); m_z = int'($signed(z));
            m_dr = 1;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bc;
        logic [7:0] r, wa, wd;
        repeat (5) @(posedge clk);
        #2;
        chk("rst_miso", miso, 1'b0);
        chk("rst_power", power_ctl, 8'h00);
        chk("rst_filter", filter_ctl, 8'h13);
        chk("rst_bad_cmd", bad_cmd, 1'b0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #2;

        // ID registers
        do_read(8'h00, 4);
        chk("id_no_bad_cmd", bad_cnt, 0);

        // Write POWER_CTL, read back FILTER_CTL/POWER_CTL
        do_write(8'h2D, 1, 8'h02, 8'h00);
        do_read(8'h2C, 2);

        // Sample burst with STATUS before and after
        do_strobe(12'hF80, 12'h07F, 12'h001);
        do_read(8'h0B, 1);
        do_read(8'h0E, 6);
        do_read(8'h0B, 1);

        // Deferred capture: strobe lands mid-frame
        m_pend = 1; p_x = 12'h123; p_y = 12'h045; p_z = -5;
        fork
            do_read(8'h0E, 2);
            begin
                repeat (30) @(posedge clk);
                #2;
                strobe_pins(12'h123, 12'h045, 12'hFFB);
            end
        join
        do_read(8'h0E, 2);

        // Unsupported command
        bc = bad_cnt;
        tx_buf[0] = 8'hFF; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        spi_frame(3, 8);
        chk("bad_cmd_pulses", bad_cnt - bc, 1);
        chk("bad_miso_b1", rx_buf[1], 8'h00);
        chk("bad_miso_b2", rx_buf[2], 8'h00);

        // Aborted write: only 5 data bits before deselect
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'h2D; tx_buf[2] = 8'h01;
        spi_frame(3, 5);
        chk("abort_power", power_ctl, m_power);

        // Reset mid-frame, then clock a frame that must be ignored
        @(posedge clk); #2;
        ss = 1'b0;
        #(HALF);
        spi_byte(8'h0B, 5, r);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("mid_rst_power", power_ctl, 8'h00);
        chk("mid_rst_filter", filter_ctl, 8'h13);
        chk("mid_rst_miso", miso, 1'b0);
        reset = 1'b0;
        m_reset();
        bc = bad_cnt;
        spi_byte(8'hFF, 8, r);
        chk("mid_rst_ign_miso", r, 8'h00);
        spi_byte(8'h0B, 8, r);
        chk("mid_rst_ign_bad", bad_cnt - bc, 0);
        #(HALF);
        ss = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        do_read(8'h00, 1);

        // Address wrap and soft reset
        do_read(8'hFF, 2);
        do_write(8'h2C, 2, 8'h05, 8'h02);
        do_write(8'h1F, 1, 8'h51, 8'h00);
        do_write(8'h1F, 1, 8'h52, 8'h00);
        chk("soft_filter", filter_ctl, 8'h13);
        chk("soft_power", power_ctl, 8'h00);

        // Randomized register traffic
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 2))
                0: do_strobe(12'($urandom), 12'($urandom), 12'($urandom));
                1: begin
                    case ($urandom_range(0, 5))
                        0:       wa = 8'h2C;
                        1:       wa = 8'h2D;
                        2:       wa = 8'h1F;
                        3:       wa = 8'h08;
                        4:       wa = 8'h00;
                        default: wa = 8'($urandom);
                    endcase
                    wd = 8'($urandom);
                    if (wa == 8'h2D && $urandom_range(0, 1) == 1) wd = 8'h02;
                    if (wa == 8'h1F && $urandom_range(0, 1) == 1) wd = 8'h52;
                    do_write(wa, $urandom_range(1, 2), wd, 8'($urandom));
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) wa = 8'($urandom_range(8'h08, 8'h13));
                    else wa = 8'($urandom);
                    do_read(wa, $urandom_range(1, 4));
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
